// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   Memory-access pipeline stage. Takes a one-hot load/store op from the M
//   register, checks its natural alignment, issues a single doubleword-aligned
//   data-bus request with byte strobes and lane-shifted store data, waits for
//   the bus response and returns the lane-extracted, sign/zero-extended load
//   result.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   regM_o_load_store_info[10:0] one-hot op: lb lh lw ld lbu lhu lwu sb sh sw sd
//   regM_o_alu_result[63:0]      effective byte address
//   regM_o_regdata2[63:0]        store data, right-justified
//   memory_i_downstream_stall    W register cannot take a result this cycle
//   dbus_o_req_valid/_addr/_wen/_wdata/_wstrb, dbus_i_req_ready   request channel
//   dbus_i_resp_valid, dbus_i_resp_rdata                        response channel
//   memory_o_rdata[63:0]         extended load result (registered)
//   memory_o_stall               hold M and upstream stages
//   memory_o_misalign            current op is misaligned (combinational)
// -----------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] regM_o_load_store_info,
  input  logic [63:0] regM_o_alu_result,
  input  logic [63:0] regM_o_regdata2,
  input  logic        memory_i_downstream_stall,
  output logic        dbus_o_req_valid,
  input  logic        dbus_i_req_ready,
  output logic [63:0] dbus_o_req_addr,
  output logic        dbus_o_req_wen,
  output logic [63:0] dbus_o_req_wdata,
  output logic [7:0]  dbus_o_req_wstrb,
  input  logic        dbus_i_resp_valid,
  input  logic [63:0] dbus_i_resp_rdata,
  output logic [63:0] memory_o_rdata,
  output logic        memory_o_stall,
  output logic        memory_o_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic        req_valid_r;
  logic [63:0] addr_r;
  logic        wen_r;
  logic [63:0] wdata_r;
  logic [7:0]  wstrb_r;
  logic [6:0]  load_op_r;   // only the load bits matter once the request is out
  logic [2:0]  offs_r;      // byte lane of the load within the doubleword
  logic [63:0] rdata_r;

  logic        has_op_s;
  logic        is_h_s;
  logic        is_w_s;
  logic        is_d_s;
  logic        is_store_s;
  logic        misalign_s;
  logic        start_s;
  logic [5:0]  shamt_s;
  logic [7:0]  strb_base_s;
  logic [7:0]  wstrb_s;
  logic [63:0] wdata_s;
  logic        stall_s;

  // Shift the doubleword down to the addressed lane, then extend by op size.
  function automatic logic [63:0] extend_load(input logic [6:0]  op,
                                              input logic [63:0] data,
                                              input logic [2:0]  offs);
    logic [63:0] sh;
    sh = data >> {offs, 3'b000};
    if (op[0]) begin
      extend_load = {{56{sh[7]}}, sh[7:0]};
    end else if (op[1]) begin
      extend_load = {{48{sh[15]}}, sh[15:0]};
    end else if (op[2]) begin
      extend_load = {{32{sh[31]}}, sh[31:0]};
    end else if (op[4]) begin
      extend_load = {56'd0, sh[7:0]};
    end else if (op[5]) begin
      extend_load = {48'd0, sh[15:0]};
    end else if (op[6]) begin
      extend_load = {32'd0, sh[31:0]};
    end else begin
      // ld: full doubleword, already aligned so offs is zero
      extend_load = sh;
    end
  endfunction

  // Decode the incoming op: size class, alignment and request fields.
  always_comb begin
    has_op_s   = |regM_o_load_store_info;
    is_h_s     = regM_o_load_store_info[1] | regM_o_load_store_info[5] | regM_o_load_store_info[8];
    is_w_s     = regM_o_load_store_info[2] | regM_o_load_store_info[6] | regM_o_load_store_info[9];
    is_d_s     = regM_o_load_store_info[3] | regM_o_load_store_info[10];
    is_store_s = |regM_o_load_store_info[10:7];
    misalign_s = (is_h_s && (regM_o_alu_result[0]   != 1'b0))
              || (is_w_s && (regM_o_alu_result[1:0] != 2'b00))
              || (is_d_s && (regM_o_alu_result[2:0] != 3'b000));
    start_s    = has_op_s && !misalign_s;
    shamt_s    = {regM_o_alu_result[2:0], 3'b000};
    if (regM_o_load_store_info[7]) begin
      strb_base_s = 8'h01;
    end else if (regM_o_load_store_info[8]) begin
      strb_base_s = 8'h03;
    end else if (regM_o_load_store_info[9]) begin
      strb_base_s = 8'h0F;
    end else if (regM_o_load_store_info[10]) begin
      strb_base_s = 8'hFF;
    end else begin
      strb_base_s = 8'h00;
    end
    wstrb_s = strb_base_s << regM_o_alu_result[2:0];
    if (is_store_s) begin
      wdata_s = regM_o_regdata2 << shamt_s;
    end else begin
      wdata_s = 64'd0;
    end
  end

  // Stall the front of the pipe from op detection until the response lands.
  always_comb begin
    case (state_r)
      ST_IDLE: stall_s = start_s;
      ST_REQ:  stall_s = 1'b1;
      ST_WAIT: stall_s = 1'b1;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Request/response FSM with registered bus fields and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      req_valid_r <= 1'b0;
      addr_r      <= 64'd0;
      wen_r       <= 1'b0;
      wdata_r     <= 64'd0;
      wstrb_r     <= 8'h00;
      load_op_r   <= 7'd0;
      offs_r      <= 3'd0;
      rdata_r     <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_REQ;
            req_valid_r <= 1'b1;
            addr_r      <= {regM_o_alu_result[63:3], 3'b000};
            wen_r       <= is_store_s;
            wdata_r     <= wdata_s;
            wstrb_r     <= wstrb_s;
            load_op_r   <= regM_o_load_store_info[6:0];
            offs_r      <= regM_o_alu_result[2:0];
          end
        end
        ST_REQ: begin
          if (req_valid_r && dbus_i_req_ready) begin
            state_r     <= ST_WAIT;
            req_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (dbus_i_resp_valid) begin
            state_r <= ST_DONE;
            // store acknowledges leave the last load result in place
            if (!wen_r) begin
              rdata_r <= extend_load(load_op_r, dbus_i_resp_rdata, offs_r);
            end
          end
        end
        ST_DONE: begin
          if (!memory_i_downstream_stall) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign dbus_o_req_valid  = req_valid_r;
  assign dbus_o_req_addr   = addr_r;
  assign dbus_o_req_wen    = wen_r;
  assign dbus_o_req_wdata  = wdata_r;
  assign dbus_o_req_wstrb  = wstrb_r;
  assign memory_o_rdata    = rdata_r;
  assign memory_o_stall    = stall_s;
  assign memory_o_misalign = misalign_s;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//   Directed bench for mem_access. Inputs change 1 time unit after the rising
//   edge; outputs are compared 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic [10:0] info;
  logic [63:0] alu;
  logic [63:0] rd2;
  logic        ds_stall;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [63:0] rdata;
  logic        stall;
  logic        misalign;

  int pass_cnt;
  int total_cnt;

  mem_access dut (
    .clk                       (clk),
    .rst                       (rst),
    .regM_o_load_store_info    (info),
    .regM_o_alu_result         (alu),
    .regM_o_regdata2           (rd2),
    .memory_i_downstream_stall (ds_stall),
    .dbus_o_req_valid          (req_valid),
    .dbus_i_req_ready          (req_ready),
    .dbus_o_req_addr           (req_addr),
    .dbus_o_req_wen            (req_wen),
    .dbus_o_req_wdata          (req_wdata),
    .dbus_o_req_wstrb          (req_wstrb),
    .dbus_i_resp_valid         (resp_valid),
    .dbus_i_resp_rdata         (resp_rdata),
    .memory_o_rdata            (rdata),
    .memory_o_stall            (stall),
    .memory_o_misalign         (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    info       = 11'h000;
    alu        = 64'd0;
    rd2        = 64'd0;
    ds_stall   = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 64'd0;

    // ---- reset state
    tick();
    tick();
    chk("rst_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_addr",  req_addr,  64'd0);
    chk("rst_wen",   {63'd0, req_wen}, 64'd0);
    chk("rst_wstrb", {56'd0, req_wstrb}, 64'd0);
    chk("rst_wdata", req_wdata, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;
    tick();

    // ---- lb at 0x1003, immediate ready and response
    info = 11'h001; alu = 64'h1003; req_ready = 1'b1;
    #1;
    chk("lb_c0_stall", {63'd0, stall}, 64'd1);
    chk("lb_c0_valid", {63'd0, req_valid}, 64'd0);
    chk("lb_c0_misal", {63'd0, misalign}, 64'd0);
    tick();
    chk("lb_c1_valid", {63'd0, req_valid}, 64'd1);
    chk("lb_c1_addr",  req_addr, 64'h1000);
    chk("lb_c1_wen",   {63'd0, req_wen}, 64'd0);
    chk("lb_c1_wstrb", {56'd0, req_wstrb}, 64'h00);
    chk("lb_c1_stall", {63'd0, stall}, 64'd1);
    tick();
    resp_valid = 1'b1; resp_rdata = 64'h0000_0000_8000_0000;
    #1;
    chk("lb_c2_valid", {63'd0, req_valid}, 64'd0);
    chk("lb_c2_stall", {63'd0, stall}, 64'd1);
    tick();
    resp_valid = 1'b0; info = 11'h000;
    #1;
    chk("lb_c3_stall", {63'd0, stall}, 64'd0);
    chk("lb_rdata",    rdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick();

    // ---- sh at 0x2006, ready held low for 4 cycles
    info = 11'h100; alu = 64'h2006; rd2 = 64'hABCD; req_ready = 1'b0;
    #1;
    chk("sh_c0_stall", {63'd0, stall}, 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sh_hold_valid", {63'd0, req_valid}, 64'd1);
      chk("sh_hold_addr",  req_addr, 64'h2000);
      chk("sh_hold_wen",   {63'd0, req_wen}, 64'd1);
      chk("sh_hold_wstrb", {56'd0, req_wstrb}, 64'hC0);
      chk("sh_hold_wdata", req_wdata, 64'hABCD_0000_0000_0000);
      chk("sh_hold_stall", {63'd0, stall}, 64'd1);
      tick();
    end
    req_ready = 1'b1;
    #1;
    chk("sh_acc_valid", {63'd0, req_valid}, 64'd1);
    tick();
    req_ready = 1'b0;
    #1;
    chk("sh_wait_valid", {63'd0, req_valid}, 64'd0);
    chk("sh_wait_stall", {63'd0, stall}, 64'd1);
    tick();
    chk("sh_wait2_stall", {63'd0, stall}, 64'd1);
    resp_valid = 1'b1; resp_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    resp_valid = 1'b0; info = 11'h000;
    #1;
    chk("sh_done_stall", {63'd0, stall}, 64'd0);
    chk("sh_rdata_kept", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick();

    // ---- lw at 0x3002: misaligned, no bus activity
    info = 11'h004; alu = 64'h3002; req_ready = 1'b1;
    #1;
    chk("lw_mis_flag",  {63'd0, misalign}, 64'd1);
    chk("lw_mis_stall", {63'd0, stall}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_mis_valid", {63'd0, req_valid}, 64'd0);
      chk("lw_mis_stall2", {63'd0, stall}, 64'd0);
    end
    info = 11'h000;
    #1;
    chk("noop_misal", {63'd0, misalign}, 64'd0);
    chk("noop_stall", {63'd0, stall}, 64'd0);
    tick();

    // ---- lwu at 0x10, downstream stall holds DONE for 2 cycles
    info = 11'h040; alu = 64'h10;
    tick();
    chk("lwu_valid", {63'd0, req_valid}, 64'd1);
    chk("lwu_addr",  req_addr, 64'h10);
    tick();
    resp_valid = 1'b1; resp_rdata = 64'h0000_0000_FFFF_FFFF; ds_stall = 1'b1;
    tick();
    resp_valid = 1'b0;
    #1;
    chk("lwu_rdata", rdata, 64'h0000_0000_FFFF_FFFF);
    chk("lwu_done_stall", {63'd0, stall}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lwu_hold_stall", {63'd0, stall}, 64'd0);
      chk("lwu_hold_valid", {63'd0, req_valid}, 64'd0);
    end
    ds_stall = 1'b0; info = 11'h000;
    tick();
    chk("lwu_idle_stall", {63'd0, stall}, 64'd0);

    // ---- sw at 0x44: strobes and data on the upper word
    info = 11'h200; alu = 64'h44; rd2 = 64'h1122_3344; req_ready = 1'b0;
    tick();
    chk("sw_addr",  req_addr, 64'h40);
    chk("sw_wstrb", {56'd0, req_wstrb}, 64'hF0);
    chk("sw_wdata", req_wdata, 64'h1122_3344_0000_0000);
    req_ready = 1'b1;
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0; info = 11'h000;
    #1;
    chk("sw_rdata_kept", rdata, 64'h0000_0000_FFFF_FFFF);
    tick();

    // ---- ld at 0x20, reset while waiting, then a late response
    info = 11'h008; alu = 64'h20;
    tick();
    tick();
    chk("ld_wait_stall", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; info = 11'h000;
    #1;
    chk("ld_rst_stall", {63'd0, stall}, 64'd0);
    chk("ld_rst_rdata", rdata, 64'd0);
    chk("ld_rst_valid", {63'd0, req_valid}, 64'd0);
    resp_valid = 1'b1; resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    #1;
    chk("late_rdata", rdata, 64'd0);
    chk("late_stall", {63'd0, stall}, 64'd0);

    // ---- fresh ld after reset: full doubleword passthrough
    info = 11'h008; alu = 64'h20;
    #1;
    chk("ld2_c0_stall", {63'd0, stall}, 64'd1);
    tick();
    chk("ld2_valid", {63'd0, req_valid}, 64'd1);
    tick();
    resp_valid = 1'b1; resp_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    resp_valid = 1'b0; info = 11'h000;
    #1;
    chk("ld2_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 regM_o_load_store_info  input  11  one-hot memory op from the M register: bit0 lb, bit1 lh, bit2 lw, bit3 ld, bit4 lbu, bit5 lhu, bit6 lwu, bit7 sb, bit8 sh, bit9 sw, bit10 sd; all-zero means no memory op.
REQ-004 regM_o_alu_result  input  64  effective byte address.
REQ-005 regM_o_regdata2  input  64  store source data, right-justified.
REQ-006 memory_i_downstream_stall  input  1  the W register cannot accept a result this cycle.
REQ-007 dbus_o_req_valid  output  1  data-bus request valid.
REQ-008 dbus_i_req_ready  input  1  the bus accepts the request when valid and ready are both high.
REQ-009 dbus_o_req_addr  output  64  doubleword-aligned address, {addr[63:3],3'b000}.
REQ-010 dbus_o_req_wen  output  1  1 = store, 0 = load.
REQ-011 dbus_o_req_wdata  output  64  store data shifted left by addr[2:0]*8.
REQ-012 dbus_o_req_wstrb  output  8  byte enables: sb 0x01, sh 0x03, sw 0x0F, sd 0xFF, shifted left by addr[2:0]; 0x00 for loads.
REQ-013 dbus_i_resp_valid  input  1  response or store acknowledge; one pulse per accepted request.
REQ-014 dbus_i_resp_rdata  input  64  aligned doubleword read data.
REQ-015 memory_o_rdata  output  64  extended load result, registered.
REQ-016 memory_o_stall  output  1  hold the M register and upstream stages.
REQ-017 memory_o_misalign  output  1  combinational flag: current memory op is misaligned.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT and DONE, encoded in a 2-bit state register.
REQ-019 An op SHALL be misaligned when: h-type and addr[0]!=0; w-type and addr[1:0]!=0; d-type and addr[2:0]!=0.
REQ-020 In IDLE, a nonzero aligned op SHALL move the FSM to REQ and latch addr, wen, wdata, wstrb and op type; a misaligned op or no op SHALL keep the FSM in IDLE and issue no bus request.
REQ-021 dbus_o_req_valid SHALL be 1 only in REQ, with all request fields stable until the accept cycle.
REQ-022 REQ SHALL move to WAIT on the cycle valid&&ready is high.
REQ-023 WAIT SHALL move to DONE on dbus_i_resp_valid; for a load, the extended result SHALL be registered into memory_o_rdata on that edge.
REQ-024 Load extraction: rdata >> (addr[2:0]*8), then sign-extend (lb/lh/lw) or zero-extend (lbu/lhu/lwu) from 8/16/32 bits; ld SHALL pass all 64 bits unchanged.
REQ-025 A store response SHALL leave memory_o_rdata unchanged.
REQ-026 dbus_i_resp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-027 DONE SHALL move to IDLE when memory_i_downstream_stall is 0 and stay in DONE while it is 1; DONE SHALL never reissue a request.
REQ-028 memory_o_stall = (IDLE && aligned nonzero op) || REQ || WAIT, combinational; it SHALL be 0 in DONE.
REQ-029 Minimum latency (ready and resp both immediate) SHALL be: op seen in cycle 0, valid in cycle 1, resp in cycle 2, DONE in cycle 3, giving a stall of 3 cycles.
REQ-030 Non-memory ops SHALL see stall=0 and 0 added latency.
REQ-031 A misaligned op SHALL assert memory_o_misalign, hold stall=0 and cause no bus activity.

Reset
REQ-032 On rst=1 the FSM SHALL go to IDLE, and req_valid, wen, wstrb, addr, wdata and memory_o_rdata SHALL all reset to 0.
REQ-033 rst SHALL take priority over every transition, including while in REQ or WAIT; a response arriving after such a reset SHALL be ignored.

Verification
REQ-034 lb at addr 0x1003, ready=1, resp data 0x0000_0000_8000_0000 -> req_addr 0x1000, wen 0, stall high for 3 cycles, rdata 0xFFFF_FFFF_FFFF_FF80.
REQ-035 sh at addr 0x2006 with data 0xABCD, ready held low 4 cycles -> valid, addr 0x2000, wstrb 0xC0 and wdata 0xABCD_0000_0000_0000 stay stable, stall stays high until resp; rdata unchanged.
REQ-036 lw at 0x3002 -> misalign=1, stall=0, req_valid never asserted.
REQ-037 lwu at 0x10 with resp 0xFFFF_FFFF; downstream_stall=1 for 2 cycles in DONE -> rdata 0x0000_0000_FFFF_FFFF, FSM stays in DONE with no second request, then returns to IDLE.
REQ-038 rst pulse while in WAIT, followed by a late resp_valid -> FSM in IDLE, stall=0, rdata 0, late response ignored.
